// File: rtl/video_out_pkg.sv
// Shared tint encodings and palette for the video output stage.
package video_out_pkg;

  typedef enum logic [1:0] {
    TINT_GREEN  = 2'b00,
    TINT_YELLOW = 2'b01,
    TINT_WHITE  = 2'b10,
    TINT_RED    = 2'b11
  } tint_e;

  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_WHITE  = 3'b111;
  localparam logic [2:0] RGB_RED    = 3'b100;

  function automatic logic [2:0] tint_to_rgb(input tint_e t);
    tint_to_rgb = RGB_GREEN;
    case (t)
      TINT_GREEN:  tint_to_rgb = RGB_GREEN;
      TINT_YELLOW: tint_to_rgb = RGB_YELLOW;
      TINT_WHITE:  tint_to_rgb = RGB_WHITE;
      TINT_RED:    tint_to_rgb = RGB_RED;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus saturating stability counter for async board switches.
module switch_debounce #(
  parameter int LEN   = 65536,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_async_i,
  output logic [WIDTH-1:0] sw_stable_o
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(LEN - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sw_async_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Any disagreement restarts the count; once full the counter holds and keeps accepting.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign sw_stable_o = stable_q;

endmodule

// File: rtl/video_outport.sv
// HDMI output stage: pixel strobe/clock divider, two-stage aligned pipeline, mono tint, power-down hold.
// Optional macro VIDEO_OUTPORT_DE_BLANK_EN blanks colour outside display_enable.
module video_outport
  import video_out_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int MONO         = 1,
  parameter int DEBOUNCE_LEN = 65536,
  parameter bit VS_POL       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] pix_rgb,
  input  logic       pix_int,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       display_enable,
  input  logic       switch2,
  input  logic       switch3,
  output logic       hdmi_red,
  output logic       hdmi_grn,
  output logic       hdmi_blu,
  output logic       hdmi_int,
  output logic       hdmi_hs,
  output logic       hdmi_vs,
  output logic       hdmi_de,
  output logic       hdmi_clk,
  output logic       hdmi_pd
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_q, div_d;
  logic          hclk_q, hclk_d;
  logic          pix_ce;

  logic [2:0] s1_rgb_q;
  logic       s1_int_q, s1_hs_q, s1_vs_q, s1_de_q;
  logic [2:0] s2_rgb_q, s2_rgb_d;
  logic       s2_int_q, s2_int_d, s2_hs_q, s2_vs_q, s2_de_q;

  tint_e      tint_q, tint_d;
  logic       pd_q, pd_d;
  logic       frame_edge;
  logic [1:0] sw_stable;

  switch_debounce #(
    .LEN   (DEBOUNCE_LEN),
    .WIDTH (2)
  ) u_switch_debounce (
    .clk         (clk),
    .reset       (reset),
    .sw_async_i  ({switch2, switch3}),
    .sw_stable_o (sw_stable)
  );

  assign pix_ce = (div_q == DIV_LAST);
  assign div_d  = pix_ce ? '0 : div_q + DW'(1);
  // Transmitter clock rises mid-pixel so the data is already settled.
  assign hclk_d = (div_d >= DIV_HALF);

  // Frame edge: the strobe on which S1 vsync moves into its active level.
  assign frame_edge = pix_ce && (vsync == VS_POL) && (s1_vs_q != VS_POL);
  assign tint_d     = frame_edge ? tint_e'(sw_stable) : tint_q;
  assign pd_d       = pd_q | frame_edge;

  always_comb begin
    s2_rgb_d = s1_rgb_q;
    s2_int_d = s1_int_q;
    if (MONO != 0) begin
      s2_rgb_d = s1_rgb_q[0] ? tint_to_rgb(tint_q) : 3'b000;
    end
`ifdef VIDEO_OUTPORT_DE_BLANK_EN
    if (!s1_de_q) begin
      s2_rgb_d = 3'b000;
      s2_int_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      hclk_q   <= 1'b0;
      s1_rgb_q <= '0;
      s1_int_q <= 1'b0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_de_q  <= 1'b0;
      s2_rgb_q <= '0;
      s2_int_q <= 1'b0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
      s2_de_q  <= 1'b0;
      tint_q   <= TINT_GREEN;
      pd_q     <= 1'b0;
    end else begin
      div_q  <= div_d;
      hclk_q <= hclk_d;
      tint_q <= tint_d;
      pd_q   <= pd_d;
      if (pix_ce) begin
        s1_rgb_q <= pix_rgb;
        s1_int_q <= pix_int;
        s1_hs_q  <= hsync;
        s1_vs_q  <= vsync;
        s1_de_q  <= display_enable;
        s2_rgb_q <= s2_rgb_d;
        s2_int_q <= s2_int_d;
        s2_hs_q  <= s1_hs_q;
        s2_vs_q  <= s1_vs_q;
        s2_de_q  <= s1_de_q;
      end
    end
  end

  assign hdmi_red = s2_rgb_q[2];
  assign hdmi_grn = s2_rgb_q[1];
  assign hdmi_blu = s2_rgb_q[0];
  assign hdmi_int = s2_int_q;
  assign hdmi_hs  = s2_hs_q;
  assign hdmi_vs  = s2_vs_q;
  assign hdmi_de  = s2_de_q;
  assign hdmi_clk = hclk_q;
  assign hdmi_pd  = pd_q;

endmodule

// File: doc/video_outport.md
Name: video_outport

Overview:
- Parametrised successor to the MDA HDMI output stage.
- Sits between the CRTC/attribute pipeline (mda or cga core) and the external HDMI transmitter pins.
- Divides the system clock into a pixel strobe and transmitter clock, and retimes video/sync/DE through an aligned pipeline.
- In mono mode, applies a debounced, frame-synchronous tint selected by the two board switches; in colour mode, passes RGBI through.
- Holds the transmitter powered down until the first complete frame boundary.

Parameters:
- CLK_DIV, 2, clk cycles per output pixel; even, 2..8.
- MONO, 1, 1 = tint pix_rgb[0] through the switch palette; 0 = pass pix_rgb/pix_int directly.
- DEBOUNCE_LEN, 65536, clk cycles the synchronised switch value must remain stable before acceptance; >= 2.
- VS_POL, 0, active level of vsync (0 = active-low, MDA); the frame edge is the transition into the active level.

Ports:
- clk  in  1  system video clock.
- reset  in  1  synchronous, active-high.
- pix_rgb  in  3  {r,g,b}; in MONO mode only bit 0 (video) is used.
- pix_int  in  1  intensity.
- hsync  in  1  horizontal sync, passed through, pipeline-aligned.
- vsync  in  1  vertical sync, passed through, pipeline-aligned.
- display_enable  in  1  active video.
- switch2  in  1  async board switch, tint MSB.
- switch3  in  1  async board switch, tint LSB.
- hdmi_red, hdmi_grn, hdmi_blu, hdmi_int  out  1 each  pixel outputs.
- hdmi_hs, hdmi_vs, hdmi_de  out  1 each  delayed sync/DE.
- hdmi_clk  out  1  transmitter pixel clock.
- hdmi_pd  out  1  transmitter power-down, active-low (0 = powered down).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates on posedge clk only.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_ce = (div_cnt == CLK_DIV-1).
- hdmi_clk is registered: 0 while div_cnt (after update) < CLK_DIV/2, else 1. The rising edge therefore falls mid-pixel, with data stable.
- Pipeline: stage S1 captures all inputs on pix_ce. Stage S2 computes colour from S1 on pix_ce and drives the outputs.
- Latency: exactly 2 pixel strobes (2*CLK_DIV clk) for every output. Sync, DE and colour stay mutually aligned.
- Switch path: 2-flop synchroniser on {switch2,switch3}, then a stability counter.
  - Counter resets whenever the synchronised value differs from the candidate.
  - When the count reaches DEBOUNCE_LEN-1, sw_stable <= candidate.
  - The counter saturates; it does not wrap.
- Tint register: loads sw_stable only on pix_ce when S1 vsync enters the active level (frame edge). It never changes mid-frame.
  - A switch change and a frame edge in the same cycle: the old sw_stable is loaded, and the new value applies next frame.
- Tint palette, {switch2,switch3} -> rgb: 00 green 010, 01 yellow 110, 10 white 111, 11 red 100.
- MONO=1: rgb = video ? tint : 000; hdmi_int = S1 pix_int.
- MONO=0: rgb = S1 pix_rgb; hdmi_int = S1 pix_int. The switches and tint are ignored.
- hdmi_pd: 0 from reset until the first frame edge, then 1 and sticky until reset.
- Reset values:
  - div_cnt = 0.
  - hdmi_clk, all colour outputs, hdmi_de and hdmi_pd = 0.
  - hdmi_hs, hdmi_vs = 0.
  - S1/S2 cleared; tint = 00; sw_stable = 00; debounce counter = 0.
- Reset mid-frame: all of the above are restored on the next clk. hdmi_pd drops to 0 immediately and re-arms on the next frame edge.

Optional Feature:
- Macro: VIDEO_OUTPORT_DE_BLANK_EN.
- Defined: in S2, hdmi_red/grn/blu/int are forced to 0 whenever S1 display_enable is 0.
- Undefined: colour passes regardless of DE. Sync and DE timing are unaffected in both cases.

Decomposition:
- Package video_out_pkg holds:
  - tint encodings TINT_GREEN/YELLOW/WHITE/RED (2-bit);
  - RGB constants for each tint (3-bit);
  - function tint_to_rgb.
- One natural sub-module: switch_debounce (synchroniser + stability counter, parameter LEN). Instantiated once, for 2 bits.

Test Plan:
- CLK_DIV=2, reset released -> hdmi_clk toggles every clk; the first pix_ce is 2 cycles after reset; hdmi_pd=0.
- CLK_DIV=4: video pulse of one pixel with DE=1 -> hdmi_grn high for exactly 4 clk, starting 8 clk after the input strobe; hdmi_de aligned.
- MONO, switches 01 held > DEBOUNCE_LEN, then a vsync frame edge -> yellow (r=1,g=1,b=0) from the following pixel; before the edge, still green.
- Switches glitch 01 for DEBOUNCE_LEN/2 then return to 00 -> tint never changes across 3 frames.
- First vsync frame edge after reset -> hdmi_pd rises to 1 on that pix_ce. Reset asserted mid-line -> all outputs 0 next clk; hdmi_pd=0 until the next edge.
- VIDEO_OUTPORT_DE_BLANK_EN defined, video=1 with DE=0 -> rgb/int=0; undefined -> green output.
